// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the single register-file write port among NUM_REQ writeback sources
// (ALU, load unit, mul/div, ...) using round-robin arbitration. The granted
// write is registered onto reg_write/WB_rd_addr/WB_rd_data one cycle after the
// grant. A pending-write scoreboard reports read-after-write hazards to decode.
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   When defined, the registered write is forwarded to decode through
//   rs1_fwd_*/rs2_fwd_*, and rsN_busy is masked during that write cycle.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (ready is a one-hot grant)
//   req_addr/req_data   packed per-requester payload, slice i = [i*W +: W]
//   issue_valid/rd      decode issues an instruction that writes issue_rd
//   rs1/rs2_addr, busy  decode source operands and their hazard flags
//   reg_write, WB_rd_*  registered register-file write port
//   rs1/rs2_fwd_*       forwarded write data (REGFILE_WB_BYPASS_EN only)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         WB_rd_addr,
  output logic [DATA_W-1:0]         WB_rd_data
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                      rs1_fwd_valid,
  output logic                      rs2_fwd_valid,
  output logic [DATA_W-1:0]         rs1_fwd_data,
  output logic [DATA_W-1:0]         rs2_fwd_data
`endif
);

  localparam int NumRegs = 2 ** ADDR_W;
  localparam int PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic               grant_any;
  logic [PtrW-1:0]    grant_idx;
  logic [ADDR_W-1:0]  grant_addr;
  logic [DATA_W-1:0]  grant_data;
  logic [NumRegs-1:0] pending_q, pending_d;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PtrW'(idx);
      end
    end
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign grant_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PtrW'(1);
    end
  end

  // Clear for the retiring write first, then set for the new producer so that
  // a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_write) begin
      pending_d[WB_rd_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      pending_q  <= '0;
      reg_write  <= 1'b0;
      WB_rd_addr <= '0;
      WB_rd_data <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      // A grant to x0 completes the handshake but never writes.
      reg_write <= grant_any && (grant_addr != '0);
      if (grant_any) begin
        WB_rd_addr <= grant_addr;
        WB_rd_data <= grant_data;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_fwd_valid = reg_write && (WB_rd_addr == rs1_addr) && (rs1_addr != '0);
  assign rs2_fwd_valid = reg_write && (WB_rd_addr == rs2_addr) && (rs2_addr != '0);
  assign rs1_fwd_data  = WB_rd_data;
  assign rs2_fwd_data  = WB_rd_data;
  assign rs1_busy      = pending_q[rs1_addr] && !rs1_fwd_valid;
  assign rs2_busy      = pending_q[rs2_addr] && !rs2_fwd_valid;
`else
  // pending_q[0] is never set, so a zero source address is never busy.
  assign rs1_busy = pending_q[rs1_addr];
  assign rs2_busy = pending_q[rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a behavioural model checked on every
// falling clock edge, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd, rs1_addr, rs2_addr;
  logic              rs1_busy, rs2_busy, reg_write;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
`ifdef REGFILE_WB_BYPASS_EN
  logic              rs1_fwd_valid, rs2_fwd_valid;
  logic [DW-1:0]     rs1_fwd_data, rs2_fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .reg_write   (reg_write),
    .WB_rd_addr  (wb_addr),
    .WB_rd_data  (wb_data)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // ---------------- behavioural model ----------------
  int            m_rr = 0;
  bit            m_we = 1'b0;
  bit [AW-1:0]   m_addr = '0;
  bit [DW-1:0]   m_data = '0;
  bit            m_pend [32];

  always @(negedge clk) begin
    int g;
    logic [NR-1:0] exp_ready;
    bit b1, b2;
    if (!rst) begin
      m_rr = 0; m_we = 0; m_addr = '0; m_data = '0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end
    g = -1;
    for (int k = 0; k < NR; k++) begin
      if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("model_req_ready", req_ready, exp_ready);
    check("ready_without_valid", req_ready & ~req_valid, 0);
    check("ready_onehot0", $onehot0(req_ready), 1);
    check("model_reg_write", reg_write, m_we);
    check("model_wb_addr", wb_addr, m_addr);
    check("model_wb_data", wb_data, m_data);
    b1 = m_pend[rs1_addr];
    b2 = m_pend[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
    begin
      bit f1, f2;
      f1 = m_we && m_addr == rs1_addr && rs1_addr != 0;
      f2 = m_we && m_addr == rs2_addr && rs2_addr != 0;
      check("model_rs1_fwd_valid", rs1_fwd_valid, f1);
      check("model_rs2_fwd_valid", rs2_fwd_valid, f2);
      if (f1) check("model_rs1_fwd_data", rs1_fwd_data, m_data);
      if (f2) check("model_rs2_fwd_data", rs2_fwd_data, m_data);
      if (f1) b1 = 1'b0;
      if (f2) b2 = 1'b0;
    end
`endif
    check("model_rs1_busy", rs1_busy, b1);
    check("model_rs2_busy", rs2_busy, b2);
    // Decode may only re-issue to a busy rd when that rd retires this cycle.
    if (issue_valid && issue_rd != 0)
      check("issue_to_busy_rd", m_pend[issue_rd] && !(m_we && m_addr == issue_rd), 0);
    if (rst) begin
      if (m_we) m_pend[m_addr] = 1'b0;
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (g >= 0) begin
        m_rr   = (g + 1) % NR;
        m_addr = req_addr[g*AW +: AW];
        m_data = req_data[g*DW +: DW];
        m_we   = (m_addr != 0);
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [2:0]    EXP_RDY  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  localparam logic [AW-1:0] EXP_ADDR [6] = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
  localparam logic [DW-1:0] EXP_DATA [6] = '{32'hA0000000, 32'hA0000100, 32'hA0000200,
                                              32'hA0000001, 32'hA0000101, 32'hA0000201};

  initial begin
    logic [NR-1:0] rdy;
    logic [NR-1:0] granted_prev;
    int wait0;
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (3) tick();
    check("reset_reg_write", reg_write, 0);
    check("reset_wb_addr", wb_addr, 0);
    check("reset_wb_data", wb_data, 0);
    rst = 1'b1;
    tick();

    // 1: reset asserted mid-stream
    issue_valid = 1'b1; issue_rd = 5'd3;
    set_req(0, 5'd20, 32'h100); set_req(1, 5'd21, 32'h101); set_req(2, 5'd22, 32'h102);
    req_valid = 3'b111;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd3;
    #1;
    check("t1_busy_before_reset", rs1_busy, 1);
    check("t1_second_grant", req_ready, 3'b010);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, AW'(8 + i), 32'hA0000000 + (i << 8));
    #1;
    check("t1_reset_reg_write", reg_write, 0);
    check("t1_reset_busy", rs1_busy, 0);
    tick();
    rst = 1'b1;

    // 2: all valid held for six grants
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t2_ready_seq", req_ready, EXP_RDY[c]);
      if (c > 0) begin
        check("t2_reg_write", reg_write, 1);
        check("t2_wb_addr", wb_addr, EXP_ADDR[c-1]);
        check("t2_wb_data", wb_data, EXP_DATA[c-1]);
      end
      tick();
      set_req(c % 3, AW'(8 + c + 3), 32'hA0000000 + ((c % 3) << 8) + (c / 3) + 1);
    end
    req_valid = '0;
    #1;
    check("t2_last_reg_write", reg_write, 1);
    check("t2_last_wb_addr", wb_addr, 5'd13);
    check("t2_last_wb_data", wb_data, 32'hA0000201);
    tick();
    check("t2_idle_reg_write", reg_write, 0);
    check("t2_hold_wb_addr", wb_addr, 5'd13);

    // 3: RAW hazard on x7 resolved by requester 1
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd7;
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    check("t3_rs1_busy", rs1_busy, 1);
    check("t3_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    check("t3_reg_write", reg_write, 1);
    check("t3_wb_addr", wb_addr, 5'd7);
    check("t3_wb_data", wb_data, 32'hDEADBEEF);
`ifdef REGFILE_WB_BYPASS_EN
    check("t3_busy_masked", rs1_busy, 0);
    check("t3_fwd_valid", rs1_fwd_valid, 1);
    check("t3_fwd_data", rs1_fwd_data, 32'hDEADBEEF);
`else
    check("t3_busy_through_write", rs1_busy, 1);
`endif
    tick();
    check("t3_busy_cleared", rs1_busy, 0);

    // 4: write to x0 is discarded
    set_req(2, 5'd0, 32'h12345678);
    req_valid = 3'b100; rs1_addr = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    check("t4_ready", req_ready, 3'b100);
    check("t4_rs1_x0_busy", rs1_busy, 0);
    tick();
    req_valid = '0; issue_valid = 1'b0;
    #1;
    check("t4_no_reg_write", reg_write, 0);
    check("t4_rs1_x0_busy_after", rs1_busy, 0);

    // 5: same-cycle set and clear on x5, set wins
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    set_req(0, 5'd5, 32'h55555555);
    req_valid = 3'b001; rs2_addr = 5'd5;
    #1;
    check("t5_busy_before", rs2_busy, 1);
    tick();
    req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    check("t5_reg_write", reg_write, 1);
    check("t5_wb_addr", wb_addr, 5'd5);
    tick();
    issue_valid = 1'b0;
    #1;
    check("t5_set_wins", rs2_busy, 1);
    tick();
    check("t5_still_busy", rs2_busy, 1);

    // 6: requester 0 held while 1 and 2 toggle
    granted_prev = '0;
    wait0 = 0;
    set_req(0, 5'd1, 32'hC0000000);
    for (int n = 0; n < 200; n++) begin
      req_valid[0] = 1'b1;
      for (int j = 1; j < NR; j++) begin
        if (!req_valid[j] || granted_prev[j]) begin
          req_valid[j] = 1'($urandom_range(0, 1));
          if (req_valid[j]) set_req(j, AW'($urandom_range(1, 31)), $urandom);
        end
      end
      #1;
      rdy = req_ready;
      wait0++;
      if (rdy[0]) begin
        check("t6_req0_wait_le_3", wait0 <= 3, 1);
        wait0 = 0;
      end
      tick();
      if (rdy[0]) set_req(0, AW'($urandom_range(1, 31)), $urandom);
      granted_prev = rdy;
    end
    req_valid = '0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
